// File: rtl/bar_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// bar_handshake_arbiter
//
// Round-robin arbiter that merges NUM_IN ready/valid producer channels into
// the single registered handshake channel consumed by bar_foo_RTL. A single
// output register stage carries the payload and its source index. It sustains
// one transfer per cycle while the consumer stays ready.
//
// Parameters:
//   NUM_IN      number of producer channels (2..8)
//   DATA_WIDTH  payload width per channel
//   SRC_W       source-index width, derived from NUM_IN
//
// Ports:
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   in_valid     per-channel valid, bit i = channel i
//   in_ready     per-channel ready (combinational, at most one bit high)
//   in_data      packed payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid    registered output valid (handshake_valid)
//   out_ready    consumer ready (handshake_ready)
//   out_data     registered payload
//   out_src      index of the channel that supplied out_data
//
// Optional feature:
//   BAR_HANDSHAKE_ARBITER_ASSERT_EN  when defined, binds a protocol checker
//   module with concurrent assertions. It has no effect on the logic.
// -----------------------------------------------------------------------------
module bar_handshake_arbiter #(
  parameter  int NUM_IN     = 3,
  parameter  int DATA_WIDTH = 4,
  localparam int SRC_W      = $clog2(NUM_IN)
) (
  input  logic                         CLK,
  input  logic                         ASYNCRESETN,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]             out_src
);

  logic [SRC_W-1:0]      rr_ptr_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SRC_W-1:0]      out_src_r;

  logic [NUM_IN-1:0]     grant_s;
  logic [SRC_W-1:0]      grant_idx_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  load_ok_s;
  logic                  accept_s;

  // Round-robin search: start just after the last granted channel and wrap.
  always_comb begin : grant_search
    logic found_v;
    int   idx_v;
    found_v      = 1'b0;
    idx_v        = 0;
    grant_s      = '0;
    grant_idx_s  = '0;
    grant_data_s = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % NUM_IN;
      if (!found_v && in_valid[idx_v]) begin
        found_v         = 1'b1;
        grant_s[idx_v]  = 1'b1;
        grant_idx_s     = SRC_W'(idx_v);
        grant_data_s    = in_data[idx_v*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        found_v = found_v;
      end
    end
  end

  // Output register can take a word when empty or being drained this cycle.
  // in_ready is forced low while reset is held so nothing is offered then.
  always_comb begin
    load_ok_s = !out_valid_r || out_ready;
    if (ASYNCRESETN) begin
      in_ready = grant_s & {NUM_IN{load_ok_s}};
    end else begin
      in_ready = '0;
    end
    accept_s = |(in_valid & in_ready);
  end

  // Output stage and round-robin pointer; pointer only moves on an accept.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
      rr_ptr_r    <= SRC_W'(NUM_IN - 1);
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_src_r   <= grant_idx_s;
      rr_ptr_r    <= grant_idx_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

`ifdef BAR_HANDSHAKE_ARBITER_ASSERT_EN
  bar_handshake_arbiter_checker #(
    .NUM_IN     (NUM_IN),
    .DATA_WIDTH (DATA_WIDTH),
    .SRC_W      (SRC_W)
  ) u_checker (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src)
  );
`endif

endmodule

`ifdef BAR_HANDSHAKE_ARBITER_ASSERT_EN
// -----------------------------------------------------------------------------
// bar_handshake_arbiter_checker
//
// Protocol and fairness assertions for bar_handshake_arbiter. Observes only;
// ports mirror the arbiter ports of the same name.
// -----------------------------------------------------------------------------
module bar_handshake_arbiter_checker #(
  parameter int NUM_IN     = 3,
  parameter int DATA_WIDTH = 4,
  parameter int SRC_W      = 2
) (
  input logic                         CLK,
  input logic                         ASYNCRESETN,
  input logic [NUM_IN-1:0]            in_valid,
  input logic [NUM_IN-1:0]            in_ready,
  input logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input logic                         out_valid,
  input logic                         out_ready,
  input logic [DATA_WIDTH-1:0]        out_data,
  input logic [SRC_W-1:0]             out_src
);

  logic accept_s;
  assign accept_s = |(in_valid & in_ready);

  a_ready_onehot0: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    $onehot0(in_ready));

  a_out_stall_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (out_valid && !out_ready) |=> ($stable(out_valid) && $stable(out_data) && $stable(out_src)));

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    logic [7:0] wait_cnt_r;

    // Accepts granted to other channels while this one keeps waiting.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        wait_cnt_r <= 8'd0;
      end else if (!in_valid[g] || in_ready[g]) begin
        wait_cnt_r <= 8'd0;
      end else if (accept_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end

    a_in_data_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      ((in_valid[g] && !in_ready[g]) ##1 in_valid[g]) |->
        $stable(in_data[g*DATA_WIDTH +: DATA_WIDTH]));

    a_no_starve: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      wait_cnt_r <= 8'(NUM_IN));
  end

endmodule
`endif
